imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, handshaked immediate generator for the pipelined core's decode stage.
//  Extracts and extends I/S/B/J/U immediates, plus CSR-uimm (Z) and shift-amount (SH),
//  to XLEN bits. Format comes from immsrc or from an internal opcode decode.
//  Flags illegal encodings and passes a sideband tag (PC) alongside. 1-cycle latency.
//  Uses a 2-entry (output + skid) buffer, so full throughput is kept under backpressure.
// PARAMETERS
//  XLEN        32  immediate width; 32 or 64 only
//  AUTO_DECODE 1   1: format derived from instr opcode/funct3; 0: format taken from immsrc
//  TAG_W       32  width of pass-through tag
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-low reset
//  in_valid   in   1      instr/immsrc/in_tag valid
//  in_ready   out  1      block can accept this cycle
//  instr      in   32     full instruction word
//  immsrc     in   3      format select (used only when AUTO_DECODE=0)
//  in_tag     in   TAG_W  sideband, returned unchanged
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  immext     out  XLEN   extended immediate
//  fmt        out  3      format actually applied (imm_fmt_t)
//  illegal    out  1      format/encoding invalid; immext forced to 0
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  Formats (imm_fmt_t): I=000 S=001 B=010 J=011 U=100 Z=101 SH=110; 111 illegal.
//  Extraction, sign-extended from instr[31] to XLEN unless noted:
//   I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0};
//   J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}, sign-extended above bit 31;
//   Z zero-extended instr[19:15]; SH zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
//  AUTO_DECODE opcode map: 0000011/1100111 ->I; 0010011 ->SH if funct3 in {001,101}, else I;
//   0100011 ->S; 1100011 ->B; 1101111 ->J; 0110111/0010111 ->U;
//   1110011 ->Z if funct3[2]=1, else I; any other opcode ->illegal.
//  illegal also set for: immsrc=111; SH with XLEN=32 and instr[25]=1.
//   On illegal: immext=0, fmt=111. Never drives X.
//  Handshake: accept when in_valid & in_ready; deliver when out_valid & out_ready.
//   Payload is stable while out_valid & !out_ready. in_ready = reset & !skid_valid (from a register).
//  Buffer: output reg (out_valid) + skid reg (skid_valid). On accept:
//   - output empty, or output delivered this cycle with skid empty -> load output reg.
//   - output held (out_valid & !out_ready) -> load skid; in_ready drops next cycle.
//   On delivery with skid_valid: skid moves into output reg and skid_valid clears. Same cycle, in_ready=0.
//  Latency: accept at cycle N -> out_valid at N+1 (output path). Sustained 1 result/cycle with out_ready=1.
//  Ordering is strict FIFO. No drop. No duplication.
//  Reset (reset=0, any cycle incl. mid-transfer): out_valid=0, skid_valid=0, immext=0, fmt=000,
//   illegal=0, out_tag=0, in_ready=0 while asserted, in_ready=1 the first cycle after release.
//   Both buffered entries are discarded.
// STRUCTURE
//  imm_pkg: imm_fmt_t enum; opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL,
//   OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM); IMM_ILLEGAL constant.
//  Sub-module imm_extract (combinational): instr, fmt -> immext, illegal; parameter XLEN.
//  Top: format select (auto/manual), then imm_extract, then output+skid registers.
// TESTING
//  1 addi 0xFFF00093, out_ready=1 -> next cycle immext=0xFFFFFFFF, fmt=I, illegal=0.
//  2 sw 0x00112623 -> 0x0000000C (S); beq 0xFE000EE3 -> 0xFFFFFFFC (B);
//    lui 0x123452B7 -> 0x12345000 (U); csrrwi 0x3002D073 -> 0x00000005 (Z).
//  3 XLEN=64 slli 0x03F09093 -> 63, fmt=SH; XLEN=32 same word -> illegal=1, immext=0;
//    XLEN=64 lui 0x800002B7 -> 0xFFFFFFFF80000000.
//  4 opcode 0x0000007F, and AUTO_DECODE=0 with immsrc=111 -> illegal=1, fmt=111, immext=0.
//  5 backpressure: stream 4 instrs with tags 1..4, out_ready low 3 cycles -> in_ready low after 2 held;
//    delivery order 1,2,3,4 with payloads unchanged, no loss.
//  6 reset pulse with both entries full -> out_valid=0, in_ready=1 after release,
//    next accepted instr appears 1 cycle later.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// immediate format encoding, opcode map and the illegal-format marker.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_J   = 3'b011,
        FMT_U   = 3'b100,
        FMT_Z   = 3'b101,
        FMT_SH  = 3'b110,
        FMT_ILL = 3'b111
    } imm_fmt_t;

    localparam imm_fmt_t IMM_ILLEGAL = FMT_ILL;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // OP-IMM with funct3 SLLI/SRLI/SRAI carries a shift amount, not an I immediate
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension for one instruction word
// under a given format; flags formats that cannot produce a valid immediate.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    // Built at 64 bits then truncated, so one expression serves both XLEN values
    logic [63:0] w_full;
    logic [51:0] w_sign52;
    logic        w_unused_bits;

    assign w_sign52 = {52{instr[31]}};

    always_comb begin
        w_full  = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I:  w_full = {w_sign52, instr[31:20]};
            FMT_S:  w_full = {w_sign52, instr[31:25], instr[11:7]};
            FMT_B:  w_full = {w_sign52[50:0], instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_J:  w_full = {w_sign52[42:0], instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            FMT_U:  w_full = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_Z:  w_full = {59'b0, instr[19:15]};
            FMT_SH: begin
                if (XLEN == 64) begin
                    w_full = {58'b0, instr[25:20]};
                end else if (instr[25]) begin
                    illegal = 1'b1;
                end else begin
                    w_full = {59'b0, instr[24:20]};
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            w_full = '0;
        end
    end

    assign immext        = w_full[XLEN-1:0];
    assign w_unused_bits = ^{instr[6:0], w_full};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator for the decode stage: format
// select, extraction, then an output register backed by a one-entry skid.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int unsigned AUTO_DECODE = 1,
    parameter int          TAG_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    imm_fmt_t        w_fmt_sel;
    imm_fmt_t        w_fmt_eff;
    logic [XLEN-1:0] w_immext;
    logic            w_illegal;
    logic            w_accept;
    logic            w_deliver;
    logic            w_unused_immsrc;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_immext;
    imm_fmt_t         r_out_fmt;
    logic             r_out_illegal;
    logic [TAG_W-1:0] r_out_tag;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_immext;
    imm_fmt_t         r_skid_fmt;
    logic             r_skid_illegal;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_opcode        = instr[6:0];
    assign w_funct3        = instr[14:12];
    assign w_unused_immsrc = ^immsrc;

    always_comb begin
        w_fmt_sel = IMM_ILLEGAL;
        if (AUTO_DECODE != 0) begin
            case (w_opcode)
                OP_LOAD, OP_JALR:  w_fmt_sel = FMT_I;
                OP_IMM:            w_fmt_sel = is_shift_funct3(w_funct3) ? FMT_SH : FMT_I;
                OP_STORE:          w_fmt_sel = FMT_S;
                OP_BRANCH:         w_fmt_sel = FMT_B;
                OP_JAL:            w_fmt_sel = FMT_J;
                OP_LUI, OP_AUIPC:  w_fmt_sel = FMT_U;
                OP_SYSTEM:         w_fmt_sel = w_funct3[2] ? FMT_Z : FMT_I;
                default:           w_fmt_sel = IMM_ILLEGAL;
            endcase
        end else begin
            w_fmt_sel = imm_fmt_t'(immsrc);
        end
    end

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr  (instr),
        .fmt    (w_fmt_sel),
        .immext (w_immext),
        .illegal(w_illegal)
    );

    assign w_fmt_eff = w_illegal ? IMM_ILLEGAL : w_fmt_sel;

    // Ready depends only on the skid register, never on out_ready, so there is
    // no combinational path from the consumer back to the producer.
    assign in_ready  = reset & ~r_skid_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid    <= 1'b0;
            r_out_immext   <= '0;
            r_out_fmt      <= FMT_I;
            r_out_illegal  <= 1'b0;
            r_out_tag      <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_immext  <= '0;
            r_skid_fmt     <= FMT_I;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= '0;
        end else if (r_skid_valid) begin
            if (w_deliver) begin
                r_out_immext  <= r_skid_immext;
                r_out_fmt     <= r_skid_fmt;
                r_out_illegal <= r_skid_illegal;
                r_out_tag     <= r_skid_tag;
                r_skid_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || w_deliver) begin
                r_out_valid   <= 1'b1;
                r_out_immext  <= w_immext;
                r_out_fmt     <= w_fmt_eff;
                r_out_illegal <= w_illegal;
                r_out_tag     <= in_tag;
            end else begin
                r_skid_valid   <= 1'b1;
                r_skid_immext  <= w_immext;
                r_skid_fmt     <= w_fmt_eff;
                r_skid_illegal <= w_illegal;
                r_skid_tag     <= in_tag;
            end
        end else if (w_deliver) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign immext    = r_out_immext;
    assign fmt       = r_out_fmt;
    assign illegal   = r_out_illegal;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (32-bit auto, 64-bit auto,
// 32-bit manual immsrc) share one input stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, tag32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  fmt64;
    logic        rdym, ovm, illm;
    logic [31:0] immm, tagm;
    logic [2:0]  fmtm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .immext(imm32), .fmt(fmt32), .illegal(ill32),
        .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .immext(imm64), .fmt(fmt64), .illegal(ill64),
        .out_tag(tag64)
    );

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(32)) dutm (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdym),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ovm),
        .out_ready(out_ready), .immext(immm), .fmt(fmtm), .illegal(illm),
        .out_tag(tagm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [31:0] e32;  logic [2:0] f32; logic i32;
        logic [63:0] e64;  logic [2:0] f64; logic i64;
        logic [31:0] em;   logic [2:0] fm;  logic im;
    } vec_t;

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; instr = '0; immsrc = '0; in_tag = '0; out_ready = 1'b1;
        step(); step();
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", ov32); end
        checks++; if (imm32 !== 32'h0) begin errors++; $display("FAIL reset_immext got %h want 0", imm32); end
        checks++; if (fmt32 !== 3'b000) begin errors++; $display("FAIL reset_fmt got %b want 000", fmt32); end
        checks++; if (ill32 !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", ill32); end
        checks++; if (tag32 !== 32'h0) begin errors++; $display("FAIL reset_tag got %h want 0", tag32); end
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %0b want 0", rdy32); end
        checks++; if (imm64 !== 64'h0) begin errors++; $display("FAIL reset_immext64 got %h want 0", imm64); end
        reset = 1'b1;
        #1;
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b want 1", rdy32); end
    endtask

    task automatic test_formats();
        vec_t v[9];
        v[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0, 32'hFFFFFFFF, 3'b000, 1'b0};
        v[1] = '{32'h00112623, 3'b001, 32'h0000000C, 3'b001, 1'b0, 64'h000000000000000C, 3'b001, 1'b0, 32'h0000000C, 3'b001, 1'b0};
        v[2] = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b010, 1'b0, 32'hFFFFFFFC, 3'b010, 1'b0};
        v[3] = '{32'h123452B7, 3'b100, 32'h12345000, 3'b100, 1'b0, 64'h0000000012345000, 3'b100, 1'b0, 32'h12345000, 3'b100, 1'b0};
        v[4] = '{32'h3002D073, 3'b101, 32'h00000005, 3'b101, 1'b0, 64'h0000000000000005, 3'b101, 1'b0, 32'h00000005, 3'b101, 1'b0};
        v[5] = '{32'h03F09093, 3'b110, 32'h00000000, 3'b111, 1'b1, 64'h000000000000003F, 3'b110, 1'b0, 32'h00000000, 3'b111, 1'b1};
        v[6] = '{32'h800002B7, 3'b100, 32'h80000000, 3'b100, 1'b0, 64'hFFFFFFFF80000000, 3'b100, 1'b0, 32'h80000000, 3'b100, 1'b0};
        v[7] = '{32'h0000007F, 3'b000, 32'h00000000, 3'b111, 1'b1, 64'h0000000000000000, 3'b111, 1'b1, 32'h00000000, 3'b000, 1'b0};
        v[8] = '{32'h008000EF, 3'b111, 32'h00000008, 3'b011, 1'b0, 64'h0000000000000008, 3'b011, 1'b0, 32'h00000000, 3'b111, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; instr = v[i].ins; immsrc = v[i].src; in_tag = 32'(i + 16);
            step();
            checks++; if (ov32 !== 1'b1 || tag32 !== 32'(i + 16)) begin errors++; $display("FAIL fmt_valid_tag[%0d] got v=%0b tag=%0d want v=1 tag=%0d", i, ov32, tag32, i + 16); end
            checks++; if (imm32 !== v[i].e32 || fmt32 !== v[i].f32 || ill32 !== v[i].i32) begin errors++; $display("FAIL x32[%0d] got imm=%h fmt=%b ill=%0b want imm=%h fmt=%b ill=%0b", i, imm32, fmt32, ill32, v[i].e32, v[i].f32, v[i].i32); end
            checks++; if (imm64 !== v[i].e64 || fmt64 !== v[i].f64 || ill64 !== v[i].i64) begin errors++; $display("FAIL x64[%0d] got imm=%h fmt=%b ill=%0b want imm=%h fmt=%b ill=%0b", i, imm64, fmt64, ill64, v[i].e64, v[i].f64, v[i].i64); end
            checks++; if (immm !== v[i].em || fmtm !== v[i].fm || illm !== v[i].im) begin errors++; $display("FAIL manual[%0d] got imm=%h fmt=%b ill=%0b want imm=%h fmt=%b ill=%0b", i, immm, fmtm, illm, v[i].em, v[i].fm, v[i].im); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL fmt_drain got %0b want 0", ov32); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; immsrc = 3'b000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = 32'hFFF00093; in_tag = 32'(100 + i);
            step();
            checks++; if (ov32 !== 1'b1 || tag32 !== 32'(100 + i) || rdy32 !== 1'b1) begin errors++; $display("FAIL b2b[%0d] got v=%0b tag=%0d rdy=%0b want v=1 tag=%0d rdy=1", i, ov32, tag32, rdy32, 100 + i); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", ov32); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins[4];
        logic [31:0] exp[4];
        int sent = 0;
        int got  = 0;
        logic acc, del, held;
        ins[0] = 32'hFFF00093; exp[0] = 32'hFFFFFFFF;
        ins[1] = 32'h00112623; exp[1] = 32'h0000000C;
        ins[2] = 32'hFE000EE3; exp[2] = 32'hFFFFFFFC;
        ins[3] = 32'h123452B7; exp[3] = 32'h12345000;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            if (sent < 4) begin
                in_valid = 1'b1; instr = ins[sent]; in_tag = 32'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            acc  = in_valid && rdy32;
            del  = ov32 && out_ready;
            held = ov32 && !out_ready;
            if (del) begin
                checks++; if (tag32 !== 32'(got + 1) || imm32 !== exp[got]) begin errors++; $display("FAIL bp_order[%0d] got tag=%0d imm=%h want tag=%0d imm=%h", got, tag32, imm32, got + 1, exp[got]); end
                got++;
            end
            step();
            if (acc) sent++;
            if (held) begin
                checks++; if (ov32 !== 1'b1 || tag32 !== 32'(got + 1) || imm32 !== exp[got]) begin errors++; $display("FAIL bp_stable cyc%0d got v=%0b tag=%0d imm=%h want v=1 tag=%0d imm=%h", cyc, ov32, tag32, imm32, got + 1, exp[got]); end
            end
            if (cyc == 1) begin
                checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop got %0b want 0", rdy32); end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL bp_delivered got %0d want 4", got); end
        step();
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b want 0", ov32); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; immsrc = 3'b000;
        in_valid = 1'b1; instr = 32'h00112623; in_tag = 32'd7;
        step();
        in_tag = 32'd8;
        step();
        in_valid = 1'b0;
        checks++; if (rdy32 !== 1'b0 || ov32 !== 1'b1) begin errors++; $display("FAIL rst_full got rdy=%0b v=%0b want rdy=0 v=1", rdy32, ov32); end
        reset = 1'b0;
        step();
        checks++; if (ov32 !== 1'b0 || rdy32 !== 1'b0 || tag32 !== 32'h0) begin errors++; $display("FAIL rst_mid got v=%0b rdy=%0b tag=%0d want v=0 rdy=0 tag=0", ov32, rdy32, tag32); end
        reset = 1'b1;
        #1;
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rst_mid_release got %0b want 1", rdy32); end
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h008000EF; in_tag = 32'd9;
        step();
        in_valid = 1'b0;
        checks++; if (ov32 !== 1'b1 || tag32 !== 32'd9 || imm32 !== 32'h8 || fmt32 !== 3'b011) begin errors++; $display("FAIL rst_next got v=%0b tag=%0d imm=%h fmt=%b want v=1 tag=9 imm=8 fmt=011", ov32, tag32, imm32, fmt32); end
        step();
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rst_no_stale got %0b want 0", ov32); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
